adc_sample_averager: RTL
========================

Name: adc_sample_averager

Overview:
Downstream consumer of the ramp-compare ADC conversion stage. It takes each 16-bit conversion result and its one-cycle data_ready strobe, and accumulates a block of 2^k samples, where k is selectable at run time. At the end of each block it emits the rounded mean plus the block minimum and maximum, with a one-cycle valid pulse. Because the ADC result sits in bits [11:4] with bits [3:0] zero, averaging fills the low nibble with fractional resolution, so the block keeps the full 16 bits.

Parameters:
DATA_WIDTH, 16, width of adc_in and of every output data word
MAX_LOG2, 6, largest supported log2 window (64 samples); the accumulator is DATA_WIDTH+MAX_LOG2+1 bits wide

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-high reset
enable  input  1  active-high run enable
data_ready  input  1  one-cycle strobe: adc_in is valid this cycle
adc_in  input  DATA_WIDTH  conversion result from the ADC stage
avg_sel  input  3  requested log2 window k; values above MAX_LOG2 clamp to MAX_LOG2
avg_out  output  DATA_WIDTH  rounded mean of the last completed block
min_out  output  DATA_WIDTH  smallest sample in the last completed block
max_out  output  DATA_WIDTH  largest sample in the last completed block
avg_valid  output  1  one-cycle pulse when avg_out, min_out and max_out update

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: avg_out=0, min_out=0, max_out=0, avg_valid=0. Internal state: state=IDLE, acc=0, cnt=0, run_min=all-ones, run_max=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - If enable=1: latch k=min(avg_sel,MAX_LOG2), clear acc and cnt, preset run_min/run_max, go to ACCUM.
  - data_ready in the IDLE cycle is ignored.
- ACCUM, on data_ready:
  - acc += adc_in (zero-extended); cnt++.
  - run_min=min(run_min,adc_in); run_max=max(run_max,adc_in).
  - If cnt == 2^k-1 before the increment (i.e. last sample of the block), go to DONE.
- DONE (exactly one cycle):
  - Register avg_out=(acc + (k>0 ? 2^(k-1) : 0)) >> k, truncated to DATA_WIDTH. This is round-half-up; the result cannot exceed 2^DATA_WIDTH-1, so no saturation logic is required.
  - Register min_out=run_min, max_out=run_max; set avg_valid=1 for the following cycle only.
  - Re-latch k from avg_sel, clear acc/cnt, preset run_min/run_max, return to ACCUM.
  - A data_ready asserted during DONE is accepted as sample 1 of the new block; it is never dropped.
- Latency: last sample accepted at edge E; DONE during cycle E..E+1; outputs and avg_valid update at edge E+1 and avg_valid is high for cycle E+1..E+2. Result appears 2 edges after the strobe cycle.
- A k change on avg_sel mid-block takes effect only at the next block start.
- enable=0 in any state:
  - Next state IDLE; partial block discarded (acc and cnt cleared); no avg_valid.
  - avg_out, min_out and max_out hold their last values.
- Reset mid-block: all outputs go to their reset values; the partial block is discarded.
- k=0: every accepted sample produces a result equal to adc_in, with min=max=adc_in.

Test Plan:
- k=0, data_ready with adc_in=0x0AB0 -> avg_valid pulses 2 edges later; avg_out=min_out=max_out=0x0AB0.
- k=2, samples 0x0100,0x0200,0x0300,0x0400 -> avg_out=0x0280, min_out=0x0100, max_out=0x0400, exactly one avg_valid pulse.
- Rounding, k=2: samples 0,0,0,2 -> avg_out=0x0001; samples 0,0,0,1 -> avg_out=0x0000.
- Full scale, k=6: 64 samples of 0xFFFF -> avg_out=0xFFFF, no wrap; k=7 requested -> clamped, still 64 samples per result.
- k=2, enable dropped after 3 samples, then re-enabled with 4 samples of 0x0010 -> no pulse for the partial block; next avg_out=0x0010; earlier outputs held meanwhile.
- k=1, strobes on consecutive cycles including the DONE cycle: 0x0020,0x0040,0x0060,0x0080 -> two results, 0x0030 then 0x0070; no sample lost.

Source files
------------

// File: rtl/adc_sample_averager.sv
// Block averager for ADC results: accumulates 2^k samples and emits the rounded mean, min and max.
// Result registers update two edges after the last sample strobe, and avg_valid pulses for one cycle.
module adc_sample_averager #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOG2   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] adc_in,
  input  logic [2:0]            avg_sel,
  output logic [DATA_WIDTH-1:0] avg_out,
  output logic [DATA_WIDTH-1:0] min_out,
  output logic [DATA_WIDTH-1:0] max_out,
  output logic                  avg_valid
);

  localparam int ACC_W = DATA_WIDTH + MAX_LOG2 + 1;
  localparam int CNT_W = MAX_LOG2 + 1;
  localparam logic [2:0]       K_MAX   = 3'(MAX_LOG2);
  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] run_min_q, run_min_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  valid_q, valid_d;

  logic [2:0]       k_sel;
  logic [ACC_W-1:0] sample_ext;
  logic [CNT_W-1:0] blk_last;
  logic [ACC_W-1:0] rnd;

  assign k_sel      = (avg_sel > K_MAX) ? K_MAX : avg_sel;
  assign sample_ext = {{(ACC_W-DATA_WIDTH){1'b0}}, adc_in};
  assign blk_last   = (CNT_ONE << k_q) - CNT_ONE;
  // Half an LSB of the result for round-half-up; shifts out to zero when k=0.
  assign rnd        = (ACC_ONE << k_q) >> 1;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    avg_d     = avg_q;
    min_d     = min_q;
    max_d     = max_q;
    valid_d   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ACCUM;
          k_d       = k_sel;
          acc_d     = '0;
          cnt_d     = '0;
          run_min_d = '1;
          run_max_d = '0;
        end
        ACCUM: begin
          if (data_ready) begin
            acc_d     = acc_q + sample_ext;
            cnt_d     = cnt_q + CNT_ONE;
            run_min_d = (adc_in < run_min_q) ? adc_in : run_min_q;
            run_max_d = (adc_in > run_max_q) ? adc_in : run_max_q;
            if (cnt_q == blk_last) state_d = DONE;
          end
        end
        DONE: begin
          avg_d   = DATA_WIDTH'((acc_q + rnd) >> k_q);
          min_d   = run_min_q;
          max_d   = run_max_q;
          valid_d = 1'b1;
          k_d     = k_sel;
          // A strobe here opens the next block; with k=0 it also closes it.
          if (data_ready) begin
            acc_d     = sample_ext;
            cnt_d     = CNT_ONE;
            run_min_d = adc_in;
            run_max_d = adc_in;
            state_d   = (k_sel == 3'd0) ? DONE : ACCUM;
          end else begin
            acc_d     = '0;
            cnt_d     = '0;
            run_min_d = '1;
            run_max_d = '0;
            state_d   = ACCUM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      run_min_q <= '1;
      run_max_q <= '0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
    end
  end

  assign avg_out   = avg_q;
  assign min_out   = min_q;
  assign max_out   = max_q;
  assign avg_valid = valid_q;

endmodule
